datapath_regbank: RTL and testbench

//   Parametrised register bank and bus source for the bus-based CPU datapath. Holds general

---
 rtl/datapath_regbank_if.sv | 49 ++++
 rtl/datapath_regbank.sv | 115 +++++++++++
 tb/tb_datapath_regbank.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_regbank_if.sv
// rtl/datapath_regbank_if.sv - bus and register-bank signal bundle for datapath_regbank
interface datapath_regbank_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) ();
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(NREGS + 8);

  logic [WIDTH-1:0]   bus_in;
  logic               reg_wr;
  logic [RW-1:0]      wr_sel;
  logic [RW-1:0]      rd_sel_a;
  logic [RW-1:0]      rd_sel_b;
  logic [WIDTH-1:0]   rd_a;
  logic [WIDTH-1:0]   rd_b;
  logic               hazard_a;
  logic               hazard_b;
  logic               lock_en;
  logic [RW-1:0]      lock_sel;
  logic               y_in;
  logic [WIDTH-1:0]   y_val;
  logic               z_in;
  logic [2*WIDTH-1:0] alu_res;
  logic               hi_in;
  logic               lo_in;
  logic               hilo_ld;
  logic [WIDTH-1:0]   hi_val;
  logic [WIDTH-1:0]   lo_val;
  logic [WIDTH-1:0]   pc_val;
  logic [WIDTH-1:0]   mdr_val;
  logic [WIDTH-1:0]   inport_val;
  logic [WIDTH-1:0]   c_val;
  logic [SW-1:0]      src_sel;
  logic [WIDTH-1:0]   bus_out;

  modport master (
    output bus_in, reg_wr, wr_sel, rd_sel_a, rd_sel_b, lock_en, lock_sel,
           y_in, z_in, alu_res, hi_in, lo_in, hilo_ld,
           pc_val, mdr_val, inport_val, c_val, src_sel,
    input  rd_a, rd_b, hazard_a, hazard_b, y_val, hi_val, lo_val, bus_out
  );

  modport slave (
    input  bus_in, reg_wr, wr_sel, rd_sel_a, rd_sel_b, lock_en, lock_sel,
           y_in, z_in, alu_res, hi_in, lo_in, hilo_ld,
           pc_val, mdr_val, inport_val, c_val, src_sel,
    output rd_a, rd_b, hazard_a, hazard_b, y_val, hi_val, lo_val, bus_out
  );
endinterface

// File: rtl/datapath_regbank.sv
// rtl/datapath_regbank.sv - general/staging register bank with busy scoreboard and bus source mux
module datapath_regbank #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 0
) (
  input logic               clk,
  input logic               reset,
  datapath_regbank_if.slave dp
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(NREGS + 8);
  localparam logic [RW:0]   NREGS_R = NREGS[RW:0];
  localparam logic [SW-1:0] NREGS_S = NREGS[SW-1:0];

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   regs_d [NREGS];
  logic [NREGS-1:0]   busy_q, busy_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [SW-1:0]      src_off;

  // An index is live when it names a real register that is not the hardwired zero R0
  function automatic logic live(input logic [RW-1:0] idx);
    return ({1'b0, idx} < NREGS_R) && !((R0_ZERO != 0) && (idx == '0));
  endfunction

  // Next-state: bus/ALU loads, scoreboard set/clear (lock wins), HI/LO bus load over Z split
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    y_d    = y_q;
    z_d    = z_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (dp.reg_wr && live(dp.wr_sel)) begin
      regs_d[dp.wr_sel] = dp.bus_in;
      busy_d[dp.wr_sel] = 1'b0;
    end
    if (dp.lock_en && live(dp.lock_sel)) begin
      busy_d[dp.lock_sel] = 1'b1;
    end
    if (dp.y_in) y_d = dp.bus_in;
    if (dp.z_in) z_d = dp.alu_res;
    if (dp.hi_in) hi_d = dp.bus_in;
    else if (dp.hilo_ld) hi_d = z_q[2*WIDTH-1:WIDTH];
    if (dp.lo_in) lo_d = dp.bus_in;
    else if (dp.hilo_ld) lo_d = z_q[WIDTH-1:0];
  end

  // State registers with synchronous reset overriding every load
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      y_q    <= '0;
      z_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      y_q    <= y_d;
      z_q    <= z_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Read ports and hazard flags; optional same-cycle forwarding of the write data
  always_comb begin
    dp.rd_a     = '0;
    dp.rd_b     = '0;
    dp.hazard_a = 1'b0;
    dp.hazard_b = 1'b0;
    if (live(dp.rd_sel_a)) begin
      dp.hazard_a = busy_q[dp.rd_sel_a];
      if ((BYPASS != 0) && dp.reg_wr && (dp.wr_sel == dp.rd_sel_a)) dp.rd_a = dp.bus_in;
      else dp.rd_a = regs_q[dp.rd_sel_a];
    end
    if (live(dp.rd_sel_b)) begin
      dp.hazard_b = busy_q[dp.rd_sel_b];
      if ((BYPASS != 0) && dp.reg_wr && (dp.wr_sel == dp.rd_sel_b)) dp.rd_b = dp.bus_in;
      else dp.rd_b = regs_q[dp.rd_sel_b];
    end
  end

  // Shared bus source: general registers first, then staging and external sources
  always_comb begin
    dp.bus_out = '0;
    src_off    = dp.src_sel - NREGS_S;
    if (dp.src_sel < NREGS_S) begin
      if (live(dp.src_sel[RW-1:0])) dp.bus_out = regs_q[dp.src_sel[RW-1:0]];
    end else begin
      case (src_off)
        SW'(0):  dp.bus_out = hi_q;
        SW'(1):  dp.bus_out = lo_q;
        SW'(2):  dp.bus_out = z_q[2*WIDTH-1:WIDTH];
        SW'(3):  dp.bus_out = z_q[WIDTH-1:0];
        SW'(4):  dp.bus_out = dp.pc_val;
        SW'(5):  dp.bus_out = dp.mdr_val;
        SW'(6):  dp.bus_out = dp.inport_val;
        SW'(7):  dp.bus_out = dp.c_val;
        default: dp.bus_out = '0;
      endcase
    end
  end

  assign dp.y_val  = y_q;
  assign dp.hi_val = hi_q;
  assign dp.lo_val = lo_q;
endmodule

// File: tb/tb_datapath_regbank.sv
// tb/tb_datapath_regbank.sv - self-checking bench for datapath_regbank
module tb_datapath_regbank;
  localparam int W  = 32;
  localparam int N0 = 16;
  localparam int N1 = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0]   bus_in, pc_val, mdr_val, inport_val, c_val;
  logic           reg_wr, lock_en, y_in, z_in, hi_in, lo_in, hilo_ld;
  logic [3:0]     wr_sel, rd_sel_a, rd_sel_b, lock_sel;
  logic [4:0]     src_sel;
  logic [2*W-1:0] alu_res;

  datapath_regbank_if #(.WIDTH(W), .NREGS(N0)) if0 ();
  datapath_regbank_if #(.WIDTH(W), .NREGS(N1)) if1 ();

  assign if0.bus_in = bus_in;         assign if1.bus_in = bus_in;
  assign if0.reg_wr = reg_wr;         assign if1.reg_wr = reg_wr;
  assign if0.wr_sel = wr_sel;         assign if1.wr_sel = wr_sel;
  assign if0.rd_sel_a = rd_sel_a;     assign if1.rd_sel_a = rd_sel_a;
  assign if0.rd_sel_b = rd_sel_b;     assign if1.rd_sel_b = rd_sel_b;
  assign if0.lock_en = lock_en;       assign if1.lock_en = lock_en;
  assign if0.lock_sel = lock_sel;     assign if1.lock_sel = lock_sel;
  assign if0.y_in = y_in;             assign if1.y_in = y_in;
  assign if0.z_in = z_in;             assign if1.z_in = z_in;
  assign if0.alu_res = alu_res;       assign if1.alu_res = alu_res;
  assign if0.hi_in = hi_in;           assign if1.hi_in = hi_in;
  assign if0.lo_in = lo_in;           assign if1.lo_in = lo_in;
  assign if0.hilo_ld = hilo_ld;       assign if1.hilo_ld = hilo_ld;
  assign if0.pc_val = pc_val;         assign if1.pc_val = pc_val;
  assign if0.mdr_val = mdr_val;       assign if1.mdr_val = mdr_val;
  assign if0.inport_val = inport_val; assign if1.inport_val = inport_val;
  assign if0.c_val = c_val;           assign if1.c_val = c_val;
  assign if0.src_sel = src_sel;       assign if1.src_sel = src_sel;

  // Instance 0: R0 hardwired zero, no bypass. Instance 1: 12 registers, ordinary R0, bypass.
  datapath_regbank #(.WIDTH(W), .NREGS(N0), .R0_ZERO(1), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .dp(if0.slave));
  datapath_regbank #(.WIDTH(W), .NREGS(N1), .R0_ZERO(0), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .dp(if1.slave));

  int checks = 0;
  int errors = 0;

  // Reference model state (shared staging registers; per-instance general registers)
  logic [W-1:0]   m_regs [2][16];
  bit             m_busy [2][16];
  logic [W-1:0]   m_y, m_hi, m_lo;
  logic [2*W-1:0] m_z;

  function automatic int nr(int k);
    return (k == 0) ? N0 : N1;
  endfunction

  function automatic bit live(int k, int idx);
    return (idx < nr(k)) && !(k == 0 && idx == 0);
  endfunction

  function automatic logic [W-1:0] exp_rd(int k, int idx);
    if (!live(k, idx)) return '0;
    if (k == 1 && reg_wr && int'(wr_sel) == idx) return bus_in;
    return m_regs[k][idx];
  endfunction

  function automatic logic exp_hz(int k, int idx);
    return live(k, idx) ? m_busy[k][idx] : 1'b0;
  endfunction

  function automatic logic [W-1:0] exp_bus(int k, int s);
    if (s < nr(k)) return live(k, s) ? m_regs[k][s] : '0;
    case (s - nr(k))
      0: return m_hi;
      1: return m_lo;
      2: return m_z[2*W-1:W];
      3: return m_z[W-1:0];
      4: return pc_val;
      5: return mdr_val;
      6: return inport_val;
      7: return c_val;
      default: return '0;
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] nhi, nlo;
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++) begin
          m_regs[k][i] = '0;
          m_busy[k][i] = 0;
        end
      m_y = '0; m_z = '0; m_hi = '0; m_lo = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (reg_wr && live(k, int'(wr_sel))) begin
          m_regs[k][wr_sel] = bus_in;
          m_busy[k][wr_sel] = 0;
        end
        if (lock_en && live(k, int'(lock_sel))) m_busy[k][lock_sel] = 1;
      end
      nhi = hi_in ? bus_in : (hilo_ld ? m_z[2*W-1:W] : m_hi);
      nlo = lo_in ? bus_in : (hilo_ld ? m_z[W-1:0] : m_lo);
      m_hi = nhi;
      m_lo = nlo;
      if (y_in) m_y = bus_in;
      if (z_in) m_z = alu_res;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_inst(input int k, input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic ha, input logic hb, input logic [W-1:0] y,
                          input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [W-1:0] bo);
    chk($sformatf("rd_a[%0d]", k), ra, exp_rd(k, int'(rd_sel_a)));
    chk($sformatf("rd_b[%0d]", k), rb, exp_rd(k, int'(rd_sel_b)));
    chk($sformatf("hazard_a[%0d]", k), ha, exp_hz(k, int'(rd_sel_a)));
    chk($sformatf("hazard_b[%0d]", k), hb, exp_hz(k, int'(rd_sel_b)));
    chk($sformatf("y_val[%0d]", k), y, m_y);
    chk($sformatf("hi_val[%0d]", k), hi, m_hi);
    chk($sformatf("lo_val[%0d]", k), lo, m_lo);
    chk($sformatf("bus_out[%0d] src=%0d", k, src_sel), bo, exp_bus(k, int'(src_sel)));
  endtask

  task automatic check_all();
    chk_inst(0, if0.rd_a, if0.rd_b, if0.hazard_a, if0.hazard_b, if0.y_val, if0.hi_val,
             if0.lo_val, if0.bus_out);
    chk_inst(1, if1.rd_a, if1.rd_b, if1.hazard_a, if1.hazard_b, if1.y_val, if1.hi_val,
             if1.lo_val, if1.bus_out);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 0; reg_wr = 0; lock_en = 0; y_in = 0; z_in = 0; hi_in = 0; lo_in = 0; hilo_ld = 0;
    wr_sel = 0; lock_sel = 0; rd_sel_a = 0; rd_sel_b = 0; src_sel = 0; bus_in = '0; alu_res = '0;
  endtask

  task automatic reset_all_loads_high();
    reset = 1; reg_wr = 1; lock_en = 1; y_in = 1; z_in = 1; hi_in = 1; lo_in = 1; hilo_ld = 1;
    wr_sel = 4'd3; lock_sel = 4'd3; bus_in = 32'hFFFF_FFFF; alu_res = '1;
    step();
    idle();
    rd_sel_a = 4'd3; rd_sel_b = 4'd5; src_sel = 5'd16;
    #2;
    chk("rst rd_a0", if0.rd_a, 0);       chk("rst rd_a1", if1.rd_a, 0);
    chk("rst hazard_a0", if0.hazard_a, 0); chk("rst hazard_a1", if1.hazard_a, 0);
    chk("rst hi0", if0.hi_val, 0);       chk("rst lo0", if0.lo_val, 0);
    chk("rst y0", if0.y_val, 0);         chk("rst bus_out0", if0.bus_out, 0);
    check_all();
  endtask

  typedef struct {
    logic           reg_wr;
    logic [3:0]     wr_sel;
    logic [W-1:0]   bus_in;
    logic           lock_en;
    logic [3:0]     lock_sel;
    logic [3:0]     ra, rb;
    logic           z_in;
    logic [2*W-1:0] alu;
    logic           hi_in, hilo_ld;
    logic [4:0]     src;
    logic [W-1:0]   e_rd_a;
    logic           e_hzb;
    logic [W-1:0]   e_bus, e_hi, e_lo;
  } vec_t;

  function automatic vec_t mk(logic rw, logic [3:0] ws, logic [W-1:0] b, logic le, logic [3:0] ls,
                              logic [3:0] ra, logic [3:0] rb, logic zi, logic [2*W-1:0] alu,
                              logic hii, logic hl, logic [4:0] src, logic [W-1:0] era,
                              logic ehb, logic [W-1:0] ebus, logic [W-1:0] ehi, logic [W-1:0] elo);
    vec_t v;
    v.reg_wr = rw; v.wr_sel = ws; v.bus_in = b; v.lock_en = le; v.lock_sel = ls;
    v.ra = ra; v.rb = rb; v.z_in = zi; v.alu = alu; v.hi_in = hii; v.hilo_ld = hl; v.src = src;
    v.e_rd_a = era; v.e_hzb = ehb; v.e_bus = ebus; v.e_hi = ehi; v.e_lo = elo;
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0, 64'h0, 0, 0, 5,  32'h0, 0, 32'h0, 0, 0);
    tbl[1]  = mk(0, 0, 32'h0, 0, 0, 5, 0, 0, 64'h0, 0, 0, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
    tbl[2]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 64'h0, 0, 0, 0,  32'h0, 0, 32'h0, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0, 1, 7, 5, 0, 0, 64'h0, 0, 0, 0,  32'hDEADBEEF, 0, 32'h0, 0, 0);
    tbl[5]  = mk(1, 7, 32'h77, 0, 0, 7, 7, 0, 64'h0, 0, 0, 20, 32'h0, 1, 32'h100, 0, 0);
    tbl[6]  = mk(1, 7, 32'h88, 1, 7, 7, 7, 0, 64'h0, 0, 0, 21, 32'h77, 0, 32'h200, 0, 0);
    tbl[7]  = mk(0, 0, 32'h0, 0, 0, 7, 7, 1, 64'h00000002_80000000, 0, 0, 22,
                 32'h88, 1, 32'h300, 0, 0);
    tbl[8]  = mk(0, 0, 32'h0, 0, 0, 7, 7, 0, 64'h0, 0, 1, 18, 32'h88, 1, 32'h2, 0, 0);
    tbl[9]  = mk(0, 0, 32'h5, 0, 0, 5, 7, 1, 64'h11111111_22222222, 1, 1, 19,
                 32'hDEADBEEF, 1, 32'h80000000, 32'h2, 32'h80000000);
    tbl[10] = mk(0, 0, 32'h0, 0, 0, 5, 7, 0, 64'h0, 0, 0, 16,
                 32'hDEADBEEF, 1, 32'h5, 32'h5, 32'h80000000);
    tbl[11] = mk(0, 0, 32'h0, 0, 0, 5, 7, 0, 64'h0, 0, 1, 19,
                 32'hDEADBEEF, 1, 32'h22222222, 32'h5, 32'h80000000);
    tbl[12] = mk(0, 0, 32'h0, 0, 0, 5, 7, 0, 64'h0, 0, 0, 24,
                 32'hDEADBEEF, 1, 32'h0, 32'h11111111, 32'h22222222);

    idle();
    pc_val = 32'h100; mdr_val = 32'h200; inport_val = 32'h300; c_val = 32'h400;
    reset_all_loads_high();
    step();

    // Directed table on the R0-zero, non-bypass instance, model-checked on both
    for (int i = 0; i < 13; i++) begin
      idle();
      reg_wr = tbl[i].reg_wr; wr_sel = tbl[i].wr_sel; bus_in = tbl[i].bus_in;
      lock_en = tbl[i].lock_en; lock_sel = tbl[i].lock_sel;
      rd_sel_a = tbl[i].ra; rd_sel_b = tbl[i].rb; z_in = tbl[i].z_in; alu_res = tbl[i].alu;
      hi_in = tbl[i].hi_in; hilo_ld = tbl[i].hilo_ld; src_sel = tbl[i].src;
      #2;
      chk($sformatf("vec%0d rd_a", i), if0.rd_a, tbl[i].e_rd_a);
      chk($sformatf("vec%0d hazard_b", i), if0.hazard_b, tbl[i].e_hzb);
      chk($sformatf("vec%0d bus_out", i), if0.bus_out, tbl[i].e_bus);
      chk($sformatf("vec%0d hi_val", i), if0.hi_val, tbl[i].e_hi);
      chk($sformatf("vec%0d lo_val", i), if0.lo_val, tbl[i].e_lo);
      check_all();
      step();
    end

    // Same-cycle bypass and out-of-range index on the 12-register instance
    idle();
    reg_wr = 1; wr_sel = 4'd3; bus_in = 32'h0BADF00D; rd_sel_a = 4'd3; rd_sel_b = 4'd3;
    #2;
    chk("bypass rd_a1", if1.rd_a, 32'h0BADF00D);
    chk("nobypass rd_a0", if0.rd_a, 32'h0);
    check_all();
    step();
    idle();
    reg_wr = 1; wr_sel = 4'd13; bus_in = 32'h13131313; lock_en = 1; lock_sel = 4'd13;
    #2;
    check_all();
    step();
    idle();
    rd_sel_a = 4'd13; rd_sel_b = 4'd3;
    #2;
    chk("oor rd_a1", if1.rd_a, 32'h0);
    chk("oor hazard_a1", if1.hazard_a, 1'b0);
    chk("r13 rd_a0", if0.rd_a, 32'h13131313);
    chk("r13 hazard_a0", if0.hazard_a, 1'b1);
    chk("r3 rd_b1", if1.rd_b, 32'h0BADF00D);
    check_all();
    step();

    // Source select sweep over every code
    idle();
    for (int s = 0; s < 32; s++) begin
      src_sel = 5'(s);
      #1;
      if (s >= N0 + 8) chk($sformatf("unmapped0 src=%0d", s), if0.bus_out, 32'h0);
      if (s >= N1 + 8) chk($sformatf("unmapped1 src=%0d", s), if1.bus_out, 32'h0);
      check_all();
    end
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      reg_wr = 1'($urandom_range(0, 1)); wr_sel = 4'($urandom);
      lock_en = ($urandom_range(0, 3) == 0); lock_sel = 4'($urandom);
      rd_sel_a = 4'($urandom); rd_sel_b = ($urandom_range(0, 1) != 0) ? wr_sel : 4'($urandom);
      y_in = 1'($urandom); z_in = 1'($urandom); hi_in = ($urandom_range(0, 3) == 0);
      lo_in = ($urandom_range(0, 3) == 0); hilo_ld = 1'($urandom);
      bus_in = $urandom; alu_res = {$urandom, $urandom}; src_sel = 5'($urandom);
      pc_val = $urandom; mdr_val = $urandom; inport_val = $urandom; c_val = $urandom;
      #2;
      check_all();
      step();
    end

    reset_all_loads_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
